game_sequencer: RTL and testbench

Top-level round controller for the pipe game. It owns the round state machine, which moves through idle, play, death animation and game over. It generates the frame-rate `enable` tick that advances the pipe/position datapath, and it counts score as pipes pass the bird. It sits between the start button and the collision/position datapath, replacing free-running enable generation.

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_sequencer_tick_gen.sv | 37 +++
 rtl/game_sequencer.sv | 145 ++++++++++++++
 tb/tb_game_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and geometry for the pipe game: round state encoding plus
// bird/pipe/screen constants used by the sequencer, position and collision blocks.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    DYING     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int SCREEN_W_PX     = 640;
  localparam int BIRD_X_PX       = 100;
  localparam int PIPE_W_PX       = 50;
  localparam int TICK_DIV_DFLT   = 4;
  localparam int DEAD_TICKS_DFLT = 8;
  localparam int SCORE_W_DFLT    = 8;

  // Right edge of a pipe; 11 bits so a pipe near the screen edge cannot wrap.
  function automatic logic [10:0] pipe_right(input logic [9:0] px, input int w);
    return {1'b0, px} + 11'(w);
  endfunction

endpackage

// File: rtl/game_sequencer_tick_gen.sv
// Frame tick divider: counts 0..TICK_DIV-1 while run is high and pulses tick
// on the last count; clear restarts the count from zero.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (clear) begin
      tcnt_d = '0;
    end else if (run) begin
      tcnt_d = (tcnt_q == LAST) ? '0 : tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign tick = run & (tcnt_q == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Round controller for the pipe game: round FSM, frame-rate enable to the
// position datapath, score counting as pipes pass the bird, and high score.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DFLT,
  parameter int BIRD_X     = BIRD_X_PX,
  parameter int PIPE_W     = PIPE_W_PX,
  parameter int DEAD_TICKS = DEAD_TICKS_DFLT,
  parameter int SCORE_W    = SCORE_W_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_button,
  input  logic               collided,
  input  logic [9:0]         pipe_x,
  output logic               enable,
  output logic               round_start,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               game_over_led
);

  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [DW-1:0]      DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [10:0]        BIRD_X_11 = 11'(BIRD_X);

  state_t state_q, state_d;

  logic               start_q;
  logic               press;
  logic               tick, tick_run, tick_clear;
  logic               enable_q, enable_d;
  logic               round_start_q, round_start_d;
  logic               passed_q, passed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [10:0]        right;

  assign press      = start_button & ~start_q;
  assign tick_run   = (state_q == PLAYING) || (state_q == DYING);
  assign tick_clear = (state_d != state_q);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .run   (tick_run),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (press) state_d = PLAYING;
      PLAYING:   if (collided) state_d = DYING;
      DYING:     if (tick && (dcnt_q == DEAD_LAST)) state_d = GAME_OVER;
      GAME_OVER: if (press) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_d      = 1'b0;
    round_start_d = 1'b0;
    game_over_led = 1'b0;
    score_d       = score_q;
    passed_d      = passed_q;
    high_d        = high_q;
    dcnt_d        = dcnt_q;
    right         = pipe_right(pipe_x, PIPE_W);
    case (state_q)
      IDLE: begin
        if (press) begin
          round_start_d = 1'b1;
          score_d       = '0;
          passed_d      = 1'b0;
        end
      end
      PLAYING: begin
        dcnt_d   = '0;
        enable_d = tick & ~collided;
        // pipe_x is only meaningful in the cycle the datapath is being advanced
        if (enable_q && !collided) begin
          if (right >= BIRD_X_11) begin
            passed_d = 1'b0;
          end else if (!passed_q) begin
            passed_d = 1'b1;
            if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
          end
        end
      end
      DYING: begin
        if (tick) begin
          if (dcnt_q == DEAD_LAST) begin
            dcnt_d = '0;
            if (score_q > high_q) high_d = score_q;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      GAME_OVER: game_over_led = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q       <= 1'b0;
      enable_q      <= 1'b0;
      round_start_q <= 1'b0;
      passed_q      <= 1'b0;
      score_q       <= '0;
      high_q        <= '0;
      dcnt_q        <= '0;
    end else begin
      start_q       <= start_button;
      enable_q      <= enable_d;
      round_start_q <= round_start_d;
      passed_q      <= passed_d;
      score_q       <= score_d;
      high_q        <= high_d;
      dcnt_q        <= dcnt_d;
    end
  end

  assign enable      = enable_q;
  assign round_start = round_start_q;
  assign state       = state_q;
  assign score       = score_q;
  assign high_score  = high_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed round scenarios plus random stimulus,
// checked against a round-level reference model kept in the bench.
module tb_game_sequencer;

  localparam int TICK_DIV     = 4;
  localparam int BIRD_X       = 100;
  localparam int PIPE_W       = 50;
  localparam int DEAD_TICKS   = 8;
  localparam int SCORE_W      = 8;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;
  localparam int DYING_CYCLES = DEAD_TICKS * TICK_DIV;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start_button = 1'b0;
  logic               collided = 1'b0;
  logic [9:0]         pipe_x = '0;
  logic               enable, round_start, game_over_led;
  logic [1:0]         state;
  logic [SCORE_W-1:0] score, high_score;
  logic [20:0]        dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: round state, cycles since entering it, score, pass latch, best score.
  int m_state, m_age, m_score, m_high;
  bit m_passed, m_prev_btn;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_DIV(TICK_DIV), .BIRD_X(BIRD_X), .PIPE_W(PIPE_W),
    .DEAD_TICKS(DEAD_TICKS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .start_button(start_button), .collided(collided),
    .pipe_x(pipe_x), .enable(enable), .round_start(round_start), .state(state),
    .score(score), .high_score(high_score), .game_over_led(game_over_led)
  );

  assign dut_vec = {state, enable, round_start, game_over_led, score, high_score};

  function automatic logic [20:0] exp_vec();
    logic en, rs, led;
    en  = (m_state == 1) && (m_age > 0) && (m_age % TICK_DIV == 0);
    rs  = (m_state == 1) && (m_age == 0);
    led = (m_state == 3);
    return {m_state[1:0], en, rs, led, m_score[SCORE_W-1:0], m_high[SCORE_W-1:0]};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_age = 0; m_score = 0; m_high = 0; m_passed = 0; m_prev_btn = 0;
  endfunction

  function automatic void model_advance(input bit btn, input bit col, input int px);
    int nxt;
    bit press, en;
    nxt   = m_state;
    press = btn && !m_prev_btn;
    en    = (m_state == 1) && (m_age > 0) && (m_age % TICK_DIV == 0);
    case (m_state)
      0: if (press) begin nxt = 1; m_score = 0; m_passed = 0; end
      1: begin
        if (col) nxt = 2;
        else if (en) begin
          if (px + PIPE_W >= BIRD_X) m_passed = 0;
          else if (!m_passed) begin
            m_passed = 1;
            if (m_score < SCORE_MAX) m_score++;
          end
        end
      end
      2: if (m_age == DYING_CYCLES - 1) begin
        nxt = 3;
        if (m_score > m_high) m_high = m_score;
      end
      default: if (press) nxt = 0;
    endcase
    m_prev_btn = btn;
    if (nxt != m_state) begin m_state = nxt; m_age = 0; end
    else m_age++;
  endfunction

  task automatic step(input logic btn, input logic col, input logic [9:0] px);
    start_button = btn; collided = col; pipe_x = px;
    model_advance(btn, col, int'(px));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame(input logic [9:0] px);
    repeat (TICK_DIV) step(1'b0, 1'b0, px);
  endtask

  task automatic die();
    step(1'b0, 1'b1, 10'd300);
    repeat (DYING_CYCLES) step(1'b0, 1'b0, 10'd300);
  endtask

  task automatic test_reset();
    reset = 1'b0; start_button = 1'b0; collided = 1'b0; pipe_x = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (dut_vec !== 21'd0) begin
      n_fail++; $display("FAIL reset_hold got %h expected 0", dut_vec);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 10'($urandom_range(0, 639)));
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_idle cyc %0d got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_start();
    int rs_cnt, en_cnt;
    rs_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(i == 0, 1'b0, 10'd300);
      rs_cnt += int'(round_start); en_cnt += int'(enable);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL start_pulse cyc %0d got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_tests++;
    if (rs_cnt != 1) begin n_fail++; $display("FAIL start_round_start_count got %0d expected 1", rs_cnt); end
    n_tests++;
    if (en_cnt != 19 / TICK_DIV) begin
      n_fail++; $display("FAIL start_enable_count got %0d expected %0d", en_cnt, 19 / TICK_DIV);
    end
    die();
    step(1'b1, 1'b0, 10'd300);
    step(1'b0, 1'b0, 10'd300);
    n_tests++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL start_back_to_idle got %0d expected 0", state); end
    rs_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(i < 10, 1'b0, 10'd300);
      rs_cnt += int'(round_start);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL start_hold cyc %0d got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_tests++;
    if (rs_cnt != 1) begin n_fail++; $display("FAIL start_hold_count got %0d expected 1", rs_cnt); end
    die();
    step(1'b1, 1'b0, 10'd300);
    step(1'b0, 1'b0, 10'd300);
  endtask

  task automatic test_scoring();
    int px_seq[5] = '{60, 49, 48, 590, 40};
    int sc_exp[5] = '{0, 1, 1, 1, 2};
    step(1'b1, 1'b0, 10'd300);
    frame(10'd300);
    for (int i = 0; i < 5; i++) begin
      frame(10'(px_seq[i]));
      n_tests++;
      if (score !== SCORE_W'(sc_exp[i]) || dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL score_seq px %0d got score %0d vec %h expected score %0d vec %h",
                 px_seq[i], score, dut_vec, sc_exp[i], exp_vec());
      end
    end
    frame(10'd590);
    step(1'b0, 1'b1, 10'd40);
    n_tests++;
    if (score !== 8'd2 || state !== 2'd2 || enable !== 1'b0) begin
      n_fail++; $display("FAIL collide_wins got score %0d state %0d en %b expected 2 2 0", score, state, enable);
    end
    for (int i = 0; i < DYING_CYCLES - 1; i++) begin
      step(i % 5 == 0, i % 3 == 0, 10'd0);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL dying cyc %0d got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    step(1'b0, 1'b0, 10'd0);
    n_tests++;
    if (state !== 2'd3 || game_over_led !== 1'b1 || high_score !== 8'd2) begin
      n_fail++;
      $display("FAIL game_over got state %0d led %b high %0d expected 3 1 2", state, game_over_led, high_score);
    end
  endtask

  task automatic test_restart_high();
    step(1'b1, 1'b0, 10'd300);
    n_tests++;
    if (state !== 2'd0 || score !== 8'd2) begin
      n_fail++; $display("FAIL restart_idle got state %0d score %0d expected 0 2", state, score);
    end
    step(1'b0, 1'b0, 10'd300);
    step(1'b1, 1'b0, 10'd300);
    n_tests++;
    if (state !== 2'd1 || score !== 8'd0 || high_score !== 8'd2 || round_start !== 1'b1) begin
      n_fail++; $display("FAIL restart_play got state %0d score %0d high %0d rs %b expected 1 0 2 1",
                         state, score, high_score, round_start);
    end
    frame(10'd300);
    die();
    n_tests++;
    if (high_score !== 8'd2 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL high_kept got high %0d vec %h expected high 2 vec %h", high_score, dut_vec, exp_vec());
    end
    step(1'b1, 1'b0, 10'd300);
    step(1'b0, 1'b0, 10'd300);
    step(1'b1, 1'b0, 10'd300);
    frame(10'd300);
    repeat (3) begin frame(10'd49); frame(10'd590); end
    n_tests++;
    if (score !== 8'd3) begin n_fail++; $display("FAIL restart_score got %0d expected 3", score); end
    die();
    n_tests++;
    if (high_score !== 8'd3 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL high_update got high %0d vec %h expected high 3 vec %h", high_score, dut_vec, exp_vec());
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 10'd300);
    step(1'b0, 1'b0, 10'd300);
    step(1'b1, 1'b0, 10'd300);
    frame(10'd300);
    for (int i = 0; i < SCORE_MAX + 3; i++) begin
      frame(10'd0);
      frame(10'd590);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL sat_pass %0d got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_tests++;
    if (score !== SCORE_W'(SCORE_MAX)) begin
      n_fail++; $display("FAIL sat_score got %0d expected %0d", score, SCORE_MAX);
    end
    die();
    n_tests++;
    if (high_score !== SCORE_W'(SCORE_MAX)) begin
      n_fail++; $display("FAIL sat_high got %0d expected %0d", high_score, SCORE_MAX);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 10'd300);
    step(1'b0, 1'b0, 10'd300);
    step(1'b1, 1'b0, 10'd300);
    frame(10'd300);
    step(1'b0, 1'b1, 10'd300);
    repeat (5) step(1'b0, 1'b0, 10'd300);
    n_tests++;
    if (state !== 2'd2 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL async_pre got %h expected %h", dut_vec, exp_vec());
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (dut_vec !== 21'd0) begin
      n_fail++; $display("FAIL async_immediate got %h expected 0", dut_vec);
    end
    model_reset();
    start_button = 1'b0; collided = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 10'd300);
    n_tests++;
    if (dut_vec !== exp_vec() || high_score !== 8'd0) begin
      n_fail++; $display("FAIL async_after got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic       btn, col;
    logic [9:0] px;
    for (int i = 0; i < 1500; i++) begin
      btn = ($urandom_range(0, 11) == 0);
      col = ($urandom_range(0, 59) == 0);
      px  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 60)) : 10'($urandom_range(0, 639));
      step(btn, col, px);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_scoring();
    test_restart_high();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
